// File: rtl/divider.sv
// ---------------------------------------------------------------------------
// divider
//
// Iterative radix-2 restoring divider for the RV32M divide/remainder ops
// (DIV, DIVU, REM, REMU). One quotient bit is produced per clock cycle. The
// execute stage stalls while busy_o is high and picks up result_o on the
// single-cycle done_o pulse.
//
// Ports
//   clk_i       : clock, all state changes on the rising edge
//   rst_ni      : asynchronous active-low reset
//   start_i     : request a division (honoured in IDLE or DONE only)
//   op_i        : alu_op_e, one of OP_DIV / OP_DIVU / OP_REM / OP_REMU
//   dividend_i  : rs1 value, sampled with start_i
//   divisor_i   : rs2 value, sampled with start_i
//   flush_i     : pipeline flush, aborts an operation in progress
//   busy_o      : iteration in progress
//   done_o      : one-cycle pulse, result_o valid in this cycle
//   result_o    : quotient or remainder, held until the next completion
// ---------------------------------------------------------------------------

package tcore_param;

  parameter int XLEN = 32;

  typedef enum logic [4:0] {
    OP_ADD,
    OP_SUB,
    OP_SLL,
    OP_SLT,
    OP_SLTU,
    OP_XOR,
    OP_SRL,
    OP_SRA,
    OP_OR,
    OP_AND,
    OP_MUL,
    OP_MULH,
    OP_MULHSU,
    OP_MULHU,
    OP_DIV,
    OP_DIVU,
    OP_REM,
    OP_REMU
  } alu_op_e;

endpackage

module divider
  import tcore_param::*;
#(
  parameter int XLEN = tcore_param::XLEN
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  alu_op_e         op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e           r_state;
  logic             r_isRem;
  logic             r_isSigned;
  logic             r_dividendSign;
  logic             r_divisorSign;
  logic [XLEN-1:0]  r_divisor;
  logic [XLEN-1:0]  r_quot;
  logic [XLEN:0]    r_rem;
  logic [CNT_W-1:0] r_count;
  logic [XLEN-1:0]  r_result;

  // Decode of the incoming request. Anything other than the four divide ops
  // falls through as unsigned quotient, i.e. behaves like DIVU.
  logic            w_opSigned;
  logic            w_opRem;
  logic            w_dividendNeg;
  logic            w_divisorNeg;
  logic [XLEN-1:0] w_absDividend;
  logic [XLEN-1:0] w_absDivisor;
  logic            w_divByZero;
  logic            w_overflow;
  logic            w_startReq;
  logic [XLEN-1:0] w_specialResult;

  assign w_opSigned    = (op_i == OP_DIV) || (op_i == OP_REM);
  assign w_opRem       = (op_i == OP_REM) || (op_i == OP_REMU);
  assign w_dividendNeg = w_opSigned & dividend_i[XLEN-1];
  assign w_divisorNeg  = w_opSigned & divisor_i[XLEN-1];
  assign w_absDividend = w_dividendNeg ? (~dividend_i + 1'b1) : dividend_i;
  assign w_absDivisor  = w_divisorNeg ? (~divisor_i + 1'b1) : divisor_i;
  assign w_divByZero   = (divisor_i == '0);
  assign w_overflow    = w_opSigned && (dividend_i == MOST_NEG) && (divisor_i == '1);
  // A flush in the same cycle always wins over a start.
  assign w_startReq    = start_i & ~flush_i;

  // Divide-by-zero and signed overflow have fixed RISC-V answers, so they
  // skip the iteration entirely. Divide-by-zero takes priority; the two
  // cannot overlap anyway since overflow needs a divisor of all ones.
  always_comb begin
    w_specialResult = '0;
    if (w_divByZero) begin
      w_specialResult = w_opRem ? dividend_i : '1;
    end else begin
      w_specialResult = w_opRem ? '0 : MOST_NEG;
    end
  end

  // One restoring step. The partial remainder is XLEN+1 bits; the trial
  // subtraction gets one extra bit so its top bit is a clean borrow flag.
  logic [XLEN:0]   w_remShift;
  logic [XLEN+1:0] w_diff;
  logic            w_fits;
  logic [XLEN:0]   w_remNext;
  logic [XLEN-1:0] w_quotNext;
  logic            w_lastStep;

  assign w_remShift = {r_rem[XLEN-1:0], r_quot[XLEN-1]};
  assign w_diff     = {1'b0, w_remShift} - {2'b00, r_divisor};
  assign w_fits     = ~w_diff[XLEN+1];
  assign w_remNext  = w_fits ? w_diff[XLEN:0] : w_remShift;
  assign w_quotNext = {r_quot[XLEN-2:0], w_fits};
  assign w_lastStep = (r_count == CNT_W'(XLEN - 1));

  // Sign fix-up applied only while writing the final result. The remainder
  // follows the dividend's sign; the quotient is negative when the operand
  // signs differ. Unsigned ops never get corrected.
  logic            w_negQuot;
  logic            w_negRem;
  logic [XLEN-1:0] w_remLow;
  logic [XLEN-1:0] w_finalQuot;
  logic [XLEN-1:0] w_finalRem;

  assign w_negQuot   = r_isSigned & (r_dividendSign ^ r_divisorSign);
  assign w_negRem    = r_isSigned & r_dividendSign;
  assign w_remLow    = w_remNext[XLEN-1:0];
  assign w_finalQuot = w_negQuot ? (~w_quotNext + 1'b1) : w_quotNext;
  assign w_finalRem  = w_negRem ? (~w_remLow + 1'b1) : w_remLow;

  // Control FSM and datapath registers. DONE behaves like IDLE for start
  // acceptance so back-to-back operations need no dead cycle between them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= IDLE;
      r_isRem        <= 1'b0;
      r_isSigned     <= 1'b0;
      r_dividendSign <= 1'b0;
      r_divisorSign  <= 1'b0;
      r_divisor      <= '0;
      r_quot         <= '0;
      r_rem          <= '0;
      r_count        <= '0;
      r_result       <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_startReq) begin
            r_isRem        <= w_opRem;
            r_isSigned     <= w_opSigned;
            r_dividendSign <= dividend_i[XLEN-1];
            r_divisorSign  <= divisor_i[XLEN-1];
            r_divisor      <= w_absDivisor;
            r_quot         <= w_absDividend;
            r_rem          <= '0;
            r_count        <= '0;
            if (w_divByZero || w_overflow) begin
              r_result <= w_specialResult;
              r_state  <= DONE;
            end else begin
              r_state <= BUSY;
            end
          end else begin
            r_state <= IDLE;
          end
        end

        BUSY: begin
          if (flush_i) begin
            r_state <= IDLE;
          end else begin
            r_rem   <= w_remNext;
            r_quot  <= w_quotNext;
            r_count <= r_count + CNT_W'(1);
            if (w_lastStep) begin
              r_result <= r_isRem ? w_finalRem : w_finalQuot;
              r_state  <= DONE;
            end
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Status outputs are plain decodes of the registered state, so nothing on
  // the inputs reaches an output in the same cycle.
  assign busy_o   = (r_state == BUSY);
  assign done_o   = (r_state == DONE);
  assign result_o = r_result;

endmodule

// File: tb/tb_divider.sv
// ---------------------------------------------------------------------------
// tb_divider
//
// Self-checking bench for divider: a directed vector table, randomized
// operations against an arithmetic reference model, and hand-written
// sequences for back-to-back, ignored start, flush and async reset.
// ---------------------------------------------------------------------------

module tb_divider;
  import tcore_param::*;

  localparam int XLEN = tcore_param::XLEN;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            flush = 1'b0;
  alu_op_e         op = OP_DIVU;
  logic [XLEN-1:0] dividend = '0;
  logic [XLEN-1:0] divisor = '0;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int              nCompared = 0;
  int              nMismatched = 0;
  logic [XLEN-1:0] lastExp = '0;

  typedef struct {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
    string       name;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  divider #(.XLEN(XLEN)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .op_i       (op),
    .dividend_i (dividend),
    .divisor_i  (divisor),
    .flush_i    (flush),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (result)
  );

  // Compare one value and log a line when it differs.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // RV32M divide semantics from plain arithmetic.
  function automatic logic [31:0] refModel(input alu_op_e o, input logic [31:0] a,
                                           input logic [31:0] b, output bit special);
    bit          isSigned;
    bit          isRem;
    longint      sa;
    longint      sb;
    longint      sq;
    longint      sr;
    longint      ua;
    longint      ub;
    logic [63:0] tmp;
    isSigned = (o == OP_DIV) || (o == OP_REM);
    isRem    = (o == OP_REM) || (o == OP_REMU);
    special  = 1'b0;
    if (b == 32'd0) begin
      special = 1'b1;
      return isRem ? a : 32'hFFFF_FFFF;
    end
    if (isSigned && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      special = 1'b1;
      return isRem ? 32'd0 : 32'h8000_0000;
    end
    if (isSigned) begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      sq  = sa / sb;
      sr  = sa % sb;
      tmp = isRem ? sr : sq;
    end else begin
      ua  = longint'({32'd0, a});
      ub  = longint'({32'd0, b});
      tmp = isRem ? (ua % ub) : (ua / ub);
    end
    return tmp[31:0];
  endfunction

  // Present a request; the start is sampled on the next rising edge.
  task automatic applyStimulus(input alu_op_e o, input logic [31:0] a,
                               input logic [31:0] b, input bit waitEdge);
    if (waitEdge) @(negedge clk);
    op       = o;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Follow one operation to its done cycle, checking the busy profile, the
  // done latency and the result. Returns in the done cycle. A nonzero
  // injectAt pulses a stray start during that cycle.
  task automatic monitor(input logic [31:0] expected, input bit special,
                         input string name, input int injectAt);
    int          lat;
    int          doneCycle;
    int          doneCount;
    int          busyErr;
    logic [31:0] resAtDone;
    lat       = special ? 1 : XLEN + 1;
    doneCycle = 0;
    doneCount = 0;
    busyErr   = 0;
    resAtDone = '0;
    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(negedge clk);
      if (injectAt > 0 && cyc == injectAt) begin
        op       = OP_DIVU;
        dividend = 32'd7;
        divisor  = 32'd1;
        start    = 1'b1;
      end
      if (injectAt > 0 && cyc == injectAt + 1) start = 1'b0;
      if (busy !== (!special && cyc <= XLEN)) busyErr++;
      if (done === 1'b1) begin
        doneCount++;
        if (doneCycle == 0) doneCycle = cyc;
      end
      if (cyc == lat) resAtDone = result;
    end
    checkOutput({name, " latency"}, doneCycle, lat);
    checkOutput({name, " busy profile"}, busyErr, 0);
    checkOutput({name, " result"}, resAtDone, expected);
    lastExp = expected;
  endtask

  // The cycle after done: pulse gone, back in IDLE, result held.
  task automatic checkTail(input string name);
    @(negedge clk);
    checkOutput({name, " tail busy/done"}, {busy, done}, 2'b00);
    checkOutput({name, " tail result held"}, result, lastExp);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          sp;
    alu_op_e     o;
    int          anyActivity;
    bit          sawDone;

    vecs[0]  = '{OP_DIVU, 32'd100,         32'd7,          32'd14,         1'b0, "DIVU 100/7"};
    vecs[1]  = '{OP_DIV,  32'hFFFF_FFEC,   32'd3,          32'hFFFF_FFFA,  1'b0, "DIV -20/3"};
    vecs[2]  = '{OP_REM,  32'hFFFF_FFF9,   32'd2,          32'hFFFF_FFFF,  1'b0, "REM -7/2"};
    vecs[3]  = '{OP_REMU, 32'hFFFF_FFFF,   32'd16,         32'd15,         1'b0, "REMU ffffffff/16"};
    vecs[4]  = '{OP_DIVU, 32'd5,           32'd0,          32'hFFFF_FFFF,  1'b1, "DIVU 5/0"};
    vecs[5]  = '{OP_REM,  32'd5,           32'd0,          32'd5,          1'b1, "REM 5/0"};
    vecs[6]  = '{OP_DIV,  32'h8000_0000,   32'hFFFF_FFFF,  32'h8000_0000,  1'b1, "DIV overflow"};
    vecs[7]  = '{OP_REM,  32'h8000_0000,   32'hFFFF_FFFF,  32'd0,          1'b1, "REM overflow"};
    vecs[8]  = '{OP_DIV,  32'd7,           32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0, "DIV 7/-2"};
    vecs[9]  = '{OP_REM,  32'd7,           32'hFFFF_FFFE,  32'd1,          1'b0, "REM 7/-2"};
    vecs[10] = '{OP_DIVU, 32'hFFFF_FFFF,   32'd1,          32'hFFFF_FFFF,  1'b0, "DIVU max/1"};
    vecs[11] = '{OP_DIV,  32'hFFFF_FFFF,   32'd0,          32'hFFFF_FFFF,  1'b1, "DIV -1/0"};
    vecs[12] = '{OP_REMU, 32'd0,           32'd5,          32'd0,          1'b0, "REMU 0/5"};
    vecs[13] = '{OP_DIVU, 32'h8000_0000,   32'hFFFF_FFFF,  32'd0,          1'b0, "DIVU 80000000/ffffffff"};
    vecs[14] = '{OP_REMU, 32'h8000_0000,   32'hFFFF_FFFF,  32'h8000_0000,  1'b0, "REMU 80000000/ffffffff"};
    vecs[15] = '{OP_ADD,  32'd100,         32'd7,          32'd14,         1'b0, "unsupported op as DIVU"};

    // Reset values, during and after reset.
    repeat (2) @(negedge clk);
    checkOutput("in reset busy/done", {busy, done}, 2'b00);
    checkOutput("in reset result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("after reset busy/done", {busy, done}, 2'b00);
    checkOutput("after reset result", result, 32'd0);

    // Directed vectors.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
      monitor(vecs[i].exp, vecs[i].special, vecs[i].name, 0);
      checkTail(vecs[i].name);
    end

    // Randomized operations with random gaps, some back-to-back.
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0:       o = OP_DIV;
        1:       o = OP_DIVU;
        2:       o = OP_REM;
        default: o = OP_REMU;
      endcase
      a = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 16);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      exp = refModel(o, a, b, sp);
      applyStimulus(o, a, b, ($urandom_range(0, 1) == 1));
      monitor(exp, sp, $sformatf("rand%0d op%0d %h/%h", i, o, a, b), 0);
    end
    checkTail("random");

    // Back-to-back: second start presented in the first one's done cycle.
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 1'b1);
    monitor(32'd14, 1'b0, "b2b first", 0);
    applyStimulus(OP_DIVU, 32'd50, 32'd5, 1'b0);
    monitor(32'd10, 1'b0, "b2b second", 0);
    applyStimulus(OP_DIVU, 32'd5, 32'd0, 1'b0);
    monitor(32'hFFFF_FFFF, 1'b1, "b2b special", 0);
    checkTail("b2b");

    // Stray start while busy must be ignored.
    applyStimulus(OP_DIVU, 32'd1000, 32'd10, 1'b1);
    monitor(32'd100, 1'b0, "ignored start", 5);
    checkTail("ignored start");

    // Flush in DONE leaves the pulse being driven alone.
    applyStimulus(OP_DIVU, 32'd6, 32'd0, 1'b1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    checkOutput("flush in done keeps pulse", done, 1'b1);
    checkOutput("flush in done result", result, 32'hFFFF_FFFF);
    lastExp = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 flush = 1'b0;
    checkTail("flush in done");

    // Flush together with start drops the start.
    @(negedge clk);
    op       = OP_DIVU;
    dividend = 32'd8;
    divisor  = 32'd2;
    start    = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    anyActivity = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) anyActivity++;
    end
    checkOutput("flush beats start", anyActivity, 0);
    checkOutput("flush beats start result", result, lastExp);

    // Flush mid-BUSY, then a new DIVU in the first IDLE cycle.
    applyStimulus(OP_DIV, 32'hFFFF_FF9C, 32'd7, 1'b1);
    sawDone = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) sawDone = 1'b1;
      if (cyc == 10) flush = 1'b1;
    end
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checkOutput("flush to idle busy", busy, 1'b0);
    checkOutput("flush no done", {sawDone, done}, 2'b00);
    checkOutput("flush result kept", result, lastExp);
    applyStimulus(OP_DIVU, 32'd9, 32'd3, 1'b0);
    monitor(32'd3, 1'b0, "after flush DIVU 9/3", 0);
    checkTail("after flush");

    // Asynchronous reset in the middle of an operation.
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 1'b1);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset busy/done", {busy, done}, 2'b00);
    checkOutput("async reset result", result, 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    lastExp = '0;
    applyStimulus(OP_DIVU, 32'd1, 32'd1, 1'b1);
    monitor(32'd1, 1'b0, "after reset DIVU 1/1", 0);
    checkTail("after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
